// File: rtl/count_bcd_display_pkg.sv
// Shared types and constants for the counter display stage: FSM state
// encoding and the active-low seven-segment lookup table.
package count_bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}, indexed by BCD digit (entry 0 is the LSB slice).
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/count_bcd_display_seg7_encode.sv
// Combinational BCD digit to active-low seven-segment encoder with blanking.
module seg7_encode
    import count_bcd_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    // Table lookup; blank request or a non-decimal nibble turns every segment off.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (digit_i <= 4'd9)) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/count_bcd_display.sv
// Display stage for the 8-bit board counter: periodically samples the count,
// converts it to BCD with a sequential double-dabble engine and drives HEX0..HEX2.
module count_bcd_display
    import count_bcd_display_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1_000_000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic       ADC_CLK_10,
    input  logic       KEY0,
    input  logic [7:0] count_in,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5
);

    if (SAMPLE_DIV < 10) begin : g_bad_sample_div
        $error("count_bcd_display: SAMPLE_DIV must be at least 10");
    end

    localparam int unsigned     DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]      LZ_RESET = BLANK_LZ ? SEG_BLANK : SEG_TABLE[0];

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [19:0]      shreg_q, shreg_d;
    logic [19:0]      adj;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       hex0_q, hex0_d;
    logic [7:0]       hex1_q, hex1_d;
    logic [7:0]       hex2_q, hex2_d;
    logic [7:0]       seg0, seg1, seg2;
    logic             tick;
    logic             blank1, blank2;

    assign tick = (div_q == DIV_LAST);

    // Leading-zero blanking decided from the finished BCD result.
    assign blank2 = BLANK_LZ && (shreg_q[19:16] == 4'd0);
    assign blank1 = blank2 && (shreg_q[15:12] == 4'd0);

    seg7_encode u_seg_ones (
        .digit_i (shreg_q[11:8]),
        .blank_i (1'b0),
        .seg_o   (seg0)
    );

    seg7_encode u_seg_tens (
        .digit_i (shreg_q[15:12]),
        .blank_i (blank1),
        .seg_o   (seg1)
    );

    seg7_encode u_seg_hund (
        .digit_i (shreg_q[19:16]),
        .blank_i (blank2),
        .seg_o   (seg2)
    );

    // Next-state logic: free-running divider, capture/shift/update sequencing.
    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hex0_d   = hex0_q;
        hex1_d   = hex1_q;
        hex2_d   = hex2_q;
        adj      = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (tick && !hold) begin
                    shreg_d  = {12'b0, count_in};
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
                if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
                if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
                shreg_d  = {adj[18:0], 1'b0};
                bitcnt_d = bitcnt_q + 4'd1;
                if (bitcnt_q == 4'd7) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                hex0_d  = seg0;
                hex1_d  = seg1;
                hex2_d  = seg2;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset that overrides any conversion.
    always_ff @(posedge ADC_CLK_10) begin
        if (!KEY0) begin
            state_q  <= IDLE;
            div_q    <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hex0_q   <= SEG_TABLE[0];
            hex1_q   <= LZ_RESET;
            hex2_q   <= LZ_RESET;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hex0_q   <= hex0_d;
            hex1_q   <= hex1_d;
            hex2_q   <= hex2_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = SEG_BLANK;
    assign HEX4 = SEG_BLANK;
    assign HEX5 = SEG_BLANK;

endmodule
